// File: rtl/adder_result_if.sv
// Handshake bundle between the ripple adder, the result stage and its consumer.
// The slave modport is the result stage; the master modport is the surrounding logic.
interface adder_result_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic             in_ready;
    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_co;
    logic             out_ovf;

    modport slave (
        input  in_valid, a_msb, b_msb, sum, co, out_ready,
        output in_ready, out_valid, out_sum, out_co, out_ovf
    );

    modport master (
        output in_valid, a_msb, b_msb, sum, co, out_ready,
        input  in_ready, out_valid, out_sum, out_co, out_ovf
    );
endinterface

// File: rtl/adder_result_stage.sv
// Two-entry skid-buffered output stage for the ripple adder, with saturating carry/overflow counters.
// Optional sticky overflow flag is built only when ADDER_RESULT_STICKY_OVF_EN is defined.
module adder_result_stage #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    adder_result_if.slave     bus,
    input  logic              clr_counts,
    output logic [CNT_W-1:0]  carry_count,
    output logic [CNT_W-1:0]  ovf_count,
    output logic              ovf_sticky
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] main_sum_reg;
    logic             main_co_reg;
    logic             main_ovf_reg;
    logic [WIDTH-1:0] skid_sum_reg;
    logic             skid_co_reg;
    logic             skid_ovf_reg;

    logic accept;
    logic pop;
    logic ovf_in;

    assign accept = bus.in_valid && in_ready_reg;
    assign pop    = out_valid_reg && bus.out_ready;
    assign ovf_in = (bus.a_msb == bus.b_msb) && (bus.sum[WIDTH-1] != bus.a_msb);

    // in_ready/out_valid are registered alongside the state so neither depends on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            main_sum_reg  <= '0;
            main_co_reg   <= 1'b0;
            main_ovf_reg  <= 1'b0;
            skid_sum_reg  <= '0;
            skid_co_reg   <= 1'b0;
            skid_ovf_reg  <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        main_sum_reg  <= bus.sum;
                        main_co_reg   <= bus.co;
                        main_ovf_reg  <= ovf_in;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_sum_reg <= bus.sum;
                        main_co_reg  <= bus.co;
                        main_ovf_reg <= ovf_in;
                    end else if (accept) begin
                        skid_sum_reg <= bus.sum;
                        skid_co_reg  <= bus.co;
                        skid_ovf_reg <= ovf_in;
                        in_ready_reg <= 1'b0;
                        state_reg    <= FULL;
                    end else if (pop) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_sum_reg <= skid_sum_reg;
                        main_co_reg  <= skid_co_reg;
                        main_ovf_reg <= skid_ovf_reg;
                        in_ready_reg <= 1'b1;
                        state_reg    <= ONE;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_sum   = main_sum_reg;
    assign bus.out_co    = main_co_reg;
    assign bus.out_ovf   = main_ovf_reg;

    // Index 0 counts carries, index 1 counts overflows; both saturate and clear wins.
    logic [1:0]            count_evt;
    logic [1:0][CNT_W-1:0] counts;

    assign count_evt = {accept && ovf_in, accept && bus.co};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_count
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst || clr_counts) begin
                    cnt_reg <= '0;
                end else if (count_evt[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign counts[gi] = cnt_reg;
        end
    endgenerate

    assign carry_count = counts[0];
    assign ovf_count   = counts[1];

`ifdef ADDER_RESULT_STICKY_OVF_EN
    logic sticky_reg;

    always_ff @(posedge clk) begin
        if (rst || clr_counts) begin
            sticky_reg <= 1'b0;
        end else if (accept && ovf_in) begin
            sticky_reg <= 1'b1;
        end
    end

    assign ovf_sticky = sticky_reg;
`else
    assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_adder_result_stage.sv
// Bench for adder_result_stage: table-driven vectors, scoreboard queue of accepted results,
// and hand sequences for backpressure, saturation, reset and the sticky flag.
module tb_adder_result_stage;
    localparam int WIDTH = 3;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             a_msb;
        logic             b_msb;
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ovf;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr_counts = 1'b0;
    logic [CNT_W-1:0] carry_count;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_sticky;

    int checks = 0;
    int errors = 0;

    adder_result_if #(.WIDTH(WIDTH)) bus ();

    adder_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clr_counts  (clr_counts),
        .carry_count (carry_count),
        .ovf_count   (ovf_count),
        .ovf_sticky  (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: the queue holds accepted-but-not-popped results, front = what out_* must show.
    vec_t exp_q[$];
    vec_t cur;
    int   m_cc = 0;
    int   m_oc = 0;
    bit   m_st = 1'b0;
    bit   acc_flag = 1'b0;
    bit   rst_prev = 1'b0;

    always @(negedge clk) begin
        bit acc;
        bit pop;
        vec_t popped;
        chk("out_valid", int'(bus.out_valid), int'(exp_q.size() > 0));
        chk("in_ready", int'(bus.in_ready), int'(exp_q.size() < 2));
        chk("carry_count", int'(carry_count), m_cc);
        chk("ovf_count", int'(ovf_count), m_oc);
        chk("ovf_sticky", int'(ovf_sticky), int'(m_st));
        if (exp_q.size() > 0) begin
            chk("out_sum", int'(bus.out_sum), int'(exp_q[0].sum));
            chk("out_co", int'(bus.out_co), int'(exp_q[0].co));
            chk("out_ovf", int'(bus.out_ovf), int'(exp_q[0].ovf));
        end else if (rst_prev) begin
            chk("rst_out_sum", int'(bus.out_sum), 0);
            chk("rst_out_co", int'(bus.out_co), 0);
            chk("rst_out_ovf", int'(bus.out_ovf), 0);
        end
        rst_prev = rst;
        acc_flag = 1'b0;
        if (rst) begin
            exp_q.delete();
            m_cc = 0;
            m_oc = 0;
            m_st = 1'b0;
        end else begin
            acc = bus.in_valid && (exp_q.size() < 2);
            pop = bus.out_ready && (exp_q.size() > 0);
            if (pop) begin
                popped = exp_q.pop_front();
                $display("pop    sum=%0d co=%0d ovf=%0d", popped.sum, popped.co, popped.ovf);
            end
            if (acc) begin
                exp_q.push_back(cur);
                acc_flag = 1'b1;
                $display("accept sum=%0d co=%0d ovf=%0d clr=%0d", cur.sum, cur.co, cur.ovf, clr_counts);
            end
            if (clr_counts) begin
                m_cc = 0;
                m_oc = 0;
                m_st = 1'b0;
            end else if (acc) begin
                if (cur.co && m_cc < CMAX) m_cc++;
                if (cur.ovf && m_oc < CMAX) m_oc++;
`ifdef ADDER_RESULT_STICKY_OVF_EN
                if (cur.ovf) m_st = 1'b1;
`endif
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the cycle that accepted the result.
    task automatic send(input vec_t v, input bit clr);
        int n = 0;
        cur = v;
        bus.a_msb = v.a_msb;
        bus.b_msb = v.b_msb;
        bus.sum = v.sum;
        bus.co = v.co;
        bus.in_valid = 1'b1;
        clr_counts = clr;
        do begin
            @(posedge clk);
            n++;
        end while (!acc_flag && n < 100);
        if (!acc_flag) chk("send_timeout", 0, 1);
        #1;
        bus.in_valid = 1'b0;
        clr_counts = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_counts = 1'b1;
        idle(1);
        clr_counts = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 0, 1);
        idle(1);
    endtask

    function automatic vec_t mk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        vec_t v;
        s = {1'b0, a} + {1'b0, b};
        v.a_msb = a[WIDTH-1];
        v.b_msb = b[WIDTH-1];
        v.sum = s[WIDTH-1:0];
        v.co = s[WIDTH];
        v.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        return v;
    endfunction

    vec_t tbl[8];
    vec_t v;

    initial begin
        // {a_msb, b_msb, sum, co, ovf} worked out by hand from the operand pairs noted
        tbl[0] = '{1'b0, 1'b0, 3'b100, 1'b0, 1'b1};  // 3+1
        tbl[1] = '{1'b1, 1'b0, 3'b000, 1'b1, 1'b0};  // 7+1
        tbl[2] = '{1'b1, 1'b1, 3'b011, 1'b1, 1'b1};  // 4+7
        tbl[3] = '{1'b0, 1'b0, 3'b011, 1'b0, 1'b0};  // 1+2
        tbl[4] = '{1'b1, 1'b1, 3'b110, 1'b1, 1'b0};  // 7+7
        tbl[5] = '{1'b0, 1'b1, 3'b111, 1'b0, 1'b0};  // 3+4
        tbl[6] = '{1'b1, 1'b1, 3'b000, 1'b1, 1'b1};  // 4+4
        tbl[7] = '{1'b0, 1'b0, 3'b010, 1'b0, 1'b0};  // 1+1

        bus.in_valid = 1'b0;
        bus.a_msb = 1'b0;
        bus.b_msb = 1'b0;
        bus.sum = '0;
        bus.co = 1'b0;
        bus.out_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // T1/T2 and further patterns, one at a time with the consumer ready
        for (int i = 0; i < 8; i++) begin
            send(tbl[i], 1'b0);
            idle(1);
        end
        drain();

        // T3: backpressure, three back to back; third held until out_ready rises
        pulse_clr();
        bus.out_ready = 1'b0;
        send(tbl[0], 1'b0);
        send(tbl[1], 1'b0);
        fork
            send(tbl[2], 1'b0);
            begin
                idle(4);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // T4: saturation with CNT_W=2, then clear together with a sixth accept
        pulse_clr();
        for (int i = 0; i < 5; i++) send(tbl[1], 1'b0);
        send(tbl[1], 1'b1);
        idle(2);
        drain();

        // T5: reset while FULL; nothing stale may emerge afterwards
        bus.out_ready = 1'b0;
        send(tbl[0], 1'b0);
        send(tbl[2], 1'b0);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        idle(4);

        // T6: one overflow then ten clean results, then a lone clear
        send(tbl[0], 1'b0);
        for (int i = 0; i < 10; i++) send(tbl[3], 1'b0);
        idle(2);
        pulse_clr();
        idle(2);

        // Random traffic with a randomly stalling consumer
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    v = mk(WIDTH'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 7)));
                    send(v, 1'b0);
                end
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #2;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
